spi_command_queue: RTL and testbench
====================================

SPI_COMMAND_QUEUE -- requirements
Module: spi_command_queue

Interface
REQ-001 Parameter: CMD_DEPTH, default 8, command FIFO entries (power of two, 2..64).
REQ-002 Parameter: RSP_DEPTH, default 4, response FIFO entries (power of two, 2..64).
REQ-003 Parameter: BUSY_TIMEOUT, default 7, cycles allowed for spi_busy to rise after a request.
REQ-004 Port clk, input, 1, sole clock; all state on rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high.
REQ-006 Ports cmd_data, cmd_write_bits, cmd_read_bits, cmd_valid / cmd_ready: input 32 / input 6 / input 6 / input 1 / output 1; command push, MSB-first frame, bit counts.
REQ-007 Ports rsp_data, rsp_valid / rsp_ready: output 32 / output 1 / input 1; read-back pop.
REQ-008 Ports spi_data_out, spi_write_bits, spi_read_bits, spi_request: output 32 / 6 / 6 / 1; drive the downstream SPI master.
REQ-009 Ports spi_busy, spi_data_in: input 1 / input 32; SPI master status and captured read word.
REQ-010 Ports cmd_level, rsp_level: output, $clog2(depth)+1 each; current FIFO occupancy.
REQ-011 Ports err_cmd, err_timeout: output 1 each; sticky error flags.

Function
REQ-012 Command push occurs when cmd_valid && cmd_ready; cmd_ready = (cmd_level < CMD_DEPTH).
REQ-013 Command with write_bits+read_bits == 0 or > 32 (7-bit sum) is not stored, sets err_cmd; cmd_ready still accepts it.
REQ-014 Response pop occurs when rsp_valid && rsp_ready; rsp_valid = (rsp_level != 0); rsp_data shows head entry combinationally from storage.
REQ-015 Both FIFOs use wrap-around read/write pointers; simultaneous push and pop on a non-empty FIFO leaves level unchanged; push on full never occurs (gated by ready).
REQ-016 Sequencer states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE.
REQ-017 IDLE -> ISSUE when command FIFO non-empty, spi_busy low, and (head read_bits == 0 or rsp_level < RSP_DEPTH); otherwise hold.
REQ-018 ISSUE: pop command, register it onto spi_data_out/spi_write_bits/spi_read_bits, assert spi_request exactly one cycle; -> WAIT_BUSY.
REQ-019 spi_data_out/spi_write_bits/spi_read_bits hold stable from ISSUE until next ISSUE.
REQ-020 WAIT_BUSY: spi_busy high -> WAIT_DONE; if BUSY_TIMEOUT cycles elapse without busy, set err_timeout, -> IDLE, no response pushed.
REQ-021 WAIT_DONE: on spi_busy low -> CAPTURE if read_bits != 0, else IDLE.
REQ-022 CAPTURE: push spi_data_in into response FIFO (space guaranteed by REQ-017), one cycle; -> IDLE.
REQ-023 Minimum spacing between consecutive spi_request pulses: one IDLE cycle after busy falls.
REQ-024 Write-only commands produce no response entry; ordering of responses equals command order.
REQ-025 err_cmd and err_timeout clear only on reset.

Reset
REQ-026 On reset: state IDLE, both FIFOs empty, pointers 0, spi_request 0, spi_data_out 0, spi_write_bits 0, spi_read_bits 0, err flags 0, rsp_valid 0, cmd_ready 1.
REQ-027 Reset mid-transfer abandons command and any pending response; spi_interface shares reset, so no request is reissued.

Verification
REQ-028 Push {0x8D000000, w=16, r=8}; SPI model returns 0x000000A5 -> one spi_request pulse, spi_write_bits=16, spi_read_bits=8, rsp_data=0x000000A5, rsp_level=1.
REQ-029 Push 3 write-only commands back-to-back -> 3 requests in order, spi_data_out matches each, rsp_level stays 0.
REQ-030 Fill RSP FIFO (4 reads, rsp_ready=0), push 5th read -> no 5th spi_request until one rsp pop; then issued.
REQ-031 Push command w=20, r=20 -> err_cmd=1, cmd_level unchanged, no spi_request.
REQ-032 SPI model never asserts busy -> err_timeout=1 after 7 cycles in WAIT_BUSY, next command issued.
REQ-033 Assert reset during WAIT_DONE with 2 queued commands -> all outputs per REQ-026 next cycle, cmd_level=0.

Source files
------------

// File: rtl/spi_command_queue.sv
// SPI command queue: buffers command frames for a downstream SPI master, sequences
// one transfer at a time and queues the read-back words for the host.
module spi_command_queue #(
    parameter int unsigned CMD_DEPTH    = 8,
    parameter int unsigned RSP_DEPTH    = 4,
    parameter int unsigned BUSY_TIMEOUT = 7,
    localparam int unsigned CmdLvlW     = $clog2(CMD_DEPTH) + 1,
    localparam int unsigned RspLvlW     = $clog2(RSP_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    // Command push
    input  logic [31:0]        cmd_data,
    input  logic [5:0]         cmd_write_bits,
    input  logic [5:0]         cmd_read_bits,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    // Response pop
    output logic [31:0]        rsp_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    // Downstream SPI master
    output logic [31:0]        spi_data_out,
    output logic [5:0]         spi_write_bits,
    output logic [5:0]         spi_read_bits,
    output logic               spi_request,
    input  logic               spi_busy,
    input  logic [31:0]        spi_data_in,
    // Status
    output logic [CmdLvlW-1:0] cmd_level,
    output logic [RspLvlW-1:0] rsp_level,
    output logic               err_cmd,
    output logic               err_timeout
);

    localparam int unsigned CmdPtrW = $clog2(CMD_DEPTH);
    localparam int unsigned RspPtrW = $clog2(RSP_DEPTH);
    localparam int unsigned CmdW    = 44;  // {data[31:0], write_bits[5:0], read_bits[5:0]}
    localparam int unsigned TmoW    = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [CmdLvlW-1:0] CmdFull = CmdLvlW'(CMD_DEPTH);
    localparam logic [RspLvlW-1:0] RspFull = RspLvlW'(RSP_DEPTH);
    localparam logic [TmoW-1:0]    TmoLast = TmoW'(BUSY_TIMEOUT - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StIssue    = 3'd1;
    localparam logic [2:0] StWaitBusy = 3'd2;
    localparam logic [2:0] StWaitDone = 3'd3;
    localparam logic [2:0] StCapture  = 3'd4;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [CmdW-1:0]    cmd_mem_q [CMD_DEPTH];
    logic [CmdPtrW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [CmdPtrW-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CmdLvlW-1:0] cmd_level_q, cmd_level_d;
    logic [6:0]         cmd_bit_sum;
    logic               cmd_legal;
    logic               cmd_accept;
    logic               cmd_push;
    logic               cmd_pop;
    logic [CmdW-1:0]    cmd_head;
    logic [5:0]         head_read_bits;

    // 7-bit sum so that 63+63 cannot wrap back into the legal range.
    assign cmd_bit_sum    = {1'b0, cmd_write_bits} + {1'b0, cmd_read_bits};
    assign cmd_legal      = (cmd_bit_sum != 7'd0) && (cmd_bit_sum <= 7'd32);
    assign cmd_ready      = (cmd_level_q < CmdFull);
    assign cmd_accept     = cmd_valid && cmd_ready;
    // Illegal frames are still handshaked so the host never stalls on them.
    assign cmd_push       = cmd_accept && cmd_legal;
    assign cmd_head       = cmd_mem_q[cmd_rd_ptr_q];
    assign head_read_bits = cmd_head[5:0];

    // Command FIFO pointer and occupancy update
    always_comb begin
        cmd_wr_ptr_d = cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        cmd_level_d  = cmd_level_q;
        if (cmd_push) begin
            cmd_wr_ptr_d = cmd_wr_ptr_q + CmdPtrW'(1);
        end
        if (cmd_pop) begin
            cmd_rd_ptr_d = cmd_rd_ptr_q + CmdPtrW'(1);
        end
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_level_d = cmd_level_q + CmdLvlW'(1);
            2'b01:   cmd_level_d = cmd_level_q - CmdLvlW'(1);
            default: cmd_level_d = cmd_level_q;
        endcase
    end

    // Command storage write
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wr_ptr_q] <= {cmd_data, cmd_write_bits, cmd_read_bits};
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [31:0]        rsp_mem_q [RSP_DEPTH];
    logic [RspPtrW-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [RspPtrW-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [RspLvlW-1:0] rsp_level_q, rsp_level_d;
    logic               rsp_push;
    logic               rsp_pop;

    assign rsp_valid = (rsp_level_q != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_mem_q[rsp_rd_ptr_q];

    // Response FIFO pointer and occupancy update
    always_comb begin
        rsp_wr_ptr_d = rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_rd_ptr_q;
        rsp_level_d  = rsp_level_q;
        if (rsp_push) begin
            rsp_wr_ptr_d = rsp_wr_ptr_q + RspPtrW'(1);
        end
        if (rsp_pop) begin
            rsp_rd_ptr_d = rsp_rd_ptr_q + RspPtrW'(1);
        end
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_level_d = rsp_level_q + RspLvlW'(1);
            2'b01:   rsp_level_d = rsp_level_q - RspLvlW'(1);
            default: rsp_level_d = rsp_level_q;
        endcase
    end

    // Response storage write
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem_q[rsp_wr_ptr_q] <= spi_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------
    logic [2:0]      state_q, state_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            spi_request_q, spi_request_d;
    logic [31:0]     spi_data_out_q, spi_data_out_d;
    logic [5:0]      spi_write_bits_q, spi_write_bits_d;
    logic [5:0]      spi_read_bits_q, spi_read_bits_d;
    logic            err_cmd_q, err_cmd_d;
    logic            err_timeout_q, err_timeout_d;
    logic            can_issue;

    // A read is only started when its response is guaranteed a slot.
    assign can_issue = (cmd_level_q != '0) && !spi_busy &&
                       ((head_read_bits == 6'd0) || (rsp_level_q < RspFull));

    assign cmd_pop  = (state_q == StIssue);
    assign rsp_push = (state_q == StCapture);

    // Sequencer next state, frame registers and sticky error flags
    always_comb begin
        state_d          = state_q;
        tmo_cnt_d        = tmo_cnt_q;
        spi_request_d    = 1'b0;
        spi_data_out_d   = spi_data_out_q;
        spi_write_bits_d = spi_write_bits_q;
        spi_read_bits_d  = spi_read_bits_q;
        err_cmd_d        = err_cmd_q | (cmd_accept && !cmd_legal);
        err_timeout_d    = err_timeout_q;

        case (state_q)
            StIdle: begin
                if (can_issue) begin
                    // Frame and request are loaded on entry so they are already
                    // on the pins for the whole ISSUE cycle, when the head pops.
                    state_d          = StIssue;
                    spi_request_d    = 1'b1;
                    spi_data_out_d   = cmd_head[43:12];
                    spi_write_bits_d = cmd_head[11:6];
                    spi_read_bits_d  = cmd_head[5:0];
                end
            end
            StIssue: begin
                state_d   = StWaitBusy;
                tmo_cnt_d = '0;
            end
            StWaitBusy: begin
                if (spi_busy) begin
                    state_d = StWaitDone;
                end else if (tmo_cnt_q == TmoLast) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StWaitDone: begin
                if (!spi_busy) begin
                    state_d = (spi_read_bits_q != 6'd0) ? StCapture : StIdle;
                end
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // All control state, with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr_ptr_q     <= '0;
            cmd_rd_ptr_q     <= '0;
            cmd_level_q      <= '0;
            rsp_wr_ptr_q     <= '0;
            rsp_rd_ptr_q     <= '0;
            rsp_level_q      <= '0;
            state_q          <= StIdle;
            tmo_cnt_q        <= '0;
            spi_request_q    <= 1'b0;
            spi_data_out_q   <= '0;
            spi_write_bits_q <= '0;
            spi_read_bits_q  <= '0;
            err_cmd_q        <= 1'b0;
            err_timeout_q    <= 1'b0;
        end else begin
            cmd_wr_ptr_q     <= cmd_wr_ptr_d;
            cmd_rd_ptr_q     <= cmd_rd_ptr_d;
            cmd_level_q      <= cmd_level_d;
            rsp_wr_ptr_q     <= rsp_wr_ptr_d;
            rsp_rd_ptr_q     <= rsp_rd_ptr_d;
            rsp_level_q      <= rsp_level_d;
            state_q          <= state_d;
            tmo_cnt_q        <= tmo_cnt_d;
            spi_request_q    <= spi_request_d;
            spi_data_out_q   <= spi_data_out_d;
            spi_write_bits_q <= spi_write_bits_d;
            spi_read_bits_q  <= spi_read_bits_d;
            err_cmd_q        <= err_cmd_d;
            err_timeout_q    <= err_timeout_d;
        end
    end

    assign spi_request    = spi_request_q;
    assign spi_data_out   = spi_data_out_q;
    assign spi_write_bits = spi_write_bits_q;
    assign spi_read_bits  = spi_read_bits_q;
    assign cmd_level      = cmd_level_q;
    assign rsp_level      = rsp_level_q;
    assign err_cmd        = err_cmd_q;
    assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_spi_command_queue.sv
// Bench for spi_command_queue: directed scenarios plus a randomized run, checked
// against a transaction-level model (expected command and response queues).
module tb_spi_command_queue;

    localparam int unsigned CMD_DEPTH    = 8;
    localparam int unsigned RSP_DEPTH    = 4;
    localparam int unsigned BUSY_TIMEOUT = 7;
    localparam logic [31:0] RespKey      = 32'h8D00_00A5;  // slave returns frame ^ key

    logic        clk;
    logic        reset;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_write_bits;
    logic [5:0]  cmd_read_bits;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] spi_data_out;
    logic [5:0]  spi_write_bits;
    logic [5:0]  spi_read_bits;
    logic        spi_request;
    logic        spi_busy;
    logic [31:0] spi_data_in;
    logic [3:0]  cmd_level;
    logic [2:0]  rsp_level;
    logic        err_cmd;
    logic        err_timeout;

    spi_command_queue #(
        .CMD_DEPTH    (CMD_DEPTH),
        .RSP_DEPTH    (RSP_DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_data       (cmd_data),
        .cmd_write_bits (cmd_write_bits),
        .cmd_read_bits  (cmd_read_bits),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .rsp_data       (rsp_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .spi_data_out   (spi_data_out),
        .spi_write_bits (spi_write_bits),
        .spi_read_bits  (spi_read_bits),
        .spi_request    (spi_request),
        .spi_busy       (spi_busy),
        .spi_data_in    (spi_data_in),
        .cmd_level      (cmd_level),
        .rsp_level      (rsp_level),
        .err_cmd        (err_cmd),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_req    = 0;
    logic [43:0] exp_cmd[$];
    logic [31:0] exp_rsp[$];
    bit          exp_err_cmd = 1'b0;
    bit          prev_req    = 1'b0;
    int          skip_busy   = 0;
    int          force_len   = 0;
    bit          m_active    = 1'b0;
    int          m_wait;
    int          m_len;
    logic [31:0] m_data;
    logic [5:0]  m_rbits;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // SPI slave model: optional start delay, busy for a few cycles, returns frame ^ key.
    initial begin : spi_model
        spi_busy    = 1'b0;
        spi_data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                spi_busy = 1'b0;
                m_active = 1'b0;
            end else if (m_active) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else if (!spi_busy) begin
                    spi_busy = 1'b1;
                end else if (m_len > 1) begin
                    m_len--;
                end else begin
                    spi_busy    = 1'b0;
                    spi_data_in = m_data ^ RespKey;
                    if (m_rbits != 6'd0) exp_rsp.push_back(spi_data_in);
                    m_active = 1'b0;
                end
            end else if (spi_request) begin
                if (skip_busy > 0) begin
                    skip_busy--;
                end else begin
                    m_active = 1'b1;
                    m_data   = spi_data_out;
                    m_rbits  = spi_read_bits;
                    m_wait   = $urandom_range(0, 2);
                    m_len    = (force_len > 0) ? force_len : $urandom_range(1, 4);
                end
            end
        end
    end

    // Monitor: checks each issued frame and popped response against the model queues.
    initial begin : monitor
        int sum;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                continue;
            end
            check_eq("cmd_ready_rule", cmd_ready, 32'(cmd_level < CMD_DEPTH));
            check_eq("rsp_valid_rule", rsp_valid, 32'(rsp_level != 0));
            check_eq("err_cmd", err_cmd, exp_err_cmd);
            if (spi_request) begin
                n_req++;
                check_eq("req_one_cycle", prev_req, 0);
                check_eq("req_pending", 32'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0) begin
                    check_eq("req_data", spi_data_out, exp_cmd[0][43:12]);
                    check_eq("req_wbits", spi_write_bits, exp_cmd[0][11:6]);
                    check_eq("req_rbits", spi_read_bits, exp_cmd[0][5:0]);
                    void'(exp_cmd.pop_front());
                end
            end
            prev_req = spi_request;
            if (rsp_valid && rsp_ready) begin
                check_eq("rsp_pending", 32'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    check_eq("rsp_data", rsp_data, exp_rsp.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                sum = int'(cmd_write_bits) + int'(cmd_read_bits);
                if (sum == 0 || sum > 32) exp_err_cmd = 1'b1;
                else exp_cmd.push_back({cmd_data, cmd_write_bits, cmd_read_bits});
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] d, input logic [5:0] w, input logic [5:0] r);
        int k = 0;
        cmd_data       = d;
        cmd_write_bits = w;
        cmd_read_bits  = r;
        cmd_valid      = 1'b1;
        while (!cmd_ready && k < 500) begin
            step();
            k++;
        end
        check_eq("push_accepted", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int k = 0;
        while (!(cmd_level == 0 && !m_active && !spi_busy) && k < bound) begin
            step();
            k++;
        end
        check_eq("settle_in_time", 32'(k < bound), 1);
        repeat (4) step();
    endtask

    task automatic clear_model();
        exp_cmd.delete();
        exp_rsp.delete();
        exp_err_cmd = 1'b0;
        skip_busy   = 0;
        force_len   = 0;
    endtask

    task automatic check_reset_state();
        check_eq("rst_request", spi_request, 0);
        check_eq("rst_data_out", spi_data_out, 0);
        check_eq("rst_wbits", spi_write_bits, 0);
        check_eq("rst_rbits", spi_read_bits, 0);
        check_eq("rst_err_cmd", err_cmd, 0);
        check_eq("rst_err_timeout", err_timeout, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_cmd_level", cmd_level, 0);
        check_eq("rst_rsp_level", rsp_level, 0);
    endtask

    initial begin : main
        int base;
        int k;
        int n;
        int w;
        int r;
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_data       = '0;
        cmd_write_bits = '0;
        cmd_read_bits  = '0;
        rsp_ready      = 1'b0;
        repeat (3) step();
        check_reset_state();
        reset = 1'b0;
        step();

        // Single read transfer
        base = n_req;
        push_cmd(32'h8D00_0000, 6'd16, 6'd8);
        wait_quiet(100);
        check_eq("t1_requests", n_req - base, 1);
        check_eq("t1_data_out", spi_data_out, 32'h8D00_0000);
        check_eq("t1_wbits", spi_write_bits, 16);
        check_eq("t1_rbits", spi_read_bits, 8);
        check_eq("t1_rsp_level", rsp_level, 1);
        check_eq("t1_rsp_data", rsp_data, 32'h0000_00A5);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("t1_rsp_drained", rsp_level, 0);

        // Back-to-back write-only commands
        base = n_req;
        push_cmd(32'h1111_1111, 6'd8, 6'd0);
        push_cmd(32'h2222_2222, 6'd16, 6'd0);
        push_cmd(32'h3333_3333, 6'd32, 6'd0);
        wait_quiet(200);
        check_eq("t2_requests", n_req - base, 3);
        check_eq("t2_last_data", spi_data_out, 32'h3333_3333);
        check_eq("t2_rsp_level", rsp_level, 0);

        // Response FIFO full blocks a fifth read until a pop
        base = n_req;
        for (int i = 0; i < 5; i++) push_cmd(32'hA000_0000 + 32'(i), 6'd8, 6'd8);
        repeat (100) step();
        check_eq("t3_requests_held", n_req - base, 4);
        check_eq("t3_rsp_full", rsp_level, 4);
        check_eq("t3_cmd_waiting", cmd_level, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        wait_quiet(100);
        check_eq("t3_requests_after_pop", n_req - base, 5);
        check_eq("t3_rsp_refilled", rsp_level, 4);
        rsp_ready = 1'b1;
        repeat (6) step();
        rsp_ready = 1'b0;
        check_eq("t3_rsp_drained", rsp_level, 0);
        check_eq("t3_model_drained", exp_rsp.size(), 0);

        // Oversized frame is swallowed and flagged
        base = n_req;
        push_cmd(32'hDEAD_BEEF, 6'd20, 6'd20);
        repeat (10) step();
        check_eq("t4_err_cmd", err_cmd, 1);
        check_eq("t4_cmd_level", cmd_level, 0);
        check_eq("t4_no_request", n_req - base, 0);
        check_eq("t4_no_timeout", err_timeout, 0);

        // Slave ignores a request: timeout after BUSY_TIMEOUT cycles, then next command runs
        base      = n_req;
        skip_busy = 1;
        push_cmd(32'h1234_5678, 6'd8, 6'd8);
        k = 0;
        while (!spi_request && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_request_seen", spi_request, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 30);
        check_eq("t5_timeout_latency", n, BUSY_TIMEOUT + 1);
        step();
        push_cmd(32'h0BAD_F00D, 6'd12, 6'd20);
        wait_quiet(100);
        check_eq("t5_err_timeout", err_timeout, 1);
        check_eq("t5_requests", n_req - base, 2);
        check_eq("t5_rsp_level", rsp_level, 1);
        check_eq("t5_rsp_data", rsp_data, 32'h0BAD_F00D ^ RespKey);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset in the middle of a transfer with two commands still queued
        base      = n_req;
        force_len = 8;
        push_cmd(32'hCAFE_0001, 6'd8, 6'd8);
        push_cmd(32'hCAFE_0002, 6'd8, 6'd0);
        push_cmd(32'hCAFE_0003, 6'd8, 6'd0);
        k = 0;
        while (!spi_busy && k < 50) begin
            step();
            k++;
        end
        check_eq("t6_busy_seen", spi_busy, 1);
        step();
        check_eq("t6_cmds_queued", cmd_level, 2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        clear_model();
        step();
        reset = 1'b0;
        repeat (20) step();
        check_eq("t6_no_reissue", n_req - base, 1);
        check_eq("t6_cmd_level", cmd_level, 0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 4);
            cmd_data  = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom_range(0, 63);
                r = $urandom_range(0, 63);
            end else begin
                w = $urandom_range(0, 32);
                r = $urandom_range(0, 32 - w);
            end
            cmd_write_bits = 6'(w);
            cmd_read_bits  = 6'(r);
            rsp_ready      = $urandom_range(0, 1);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_quiet(600);
        repeat (8) step();
        check_eq("rand_cmds_issued", exp_cmd.size(), 0);
        check_eq("rand_rsps_drained", exp_rsp.size(), 0);
        check_eq("rand_rsp_level", rsp_level, 0);
        check_eq("rand_cmd_level", cmd_level, 0);
        check_eq("rand_err_timeout", err_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
